// File: rtl/m_mem_access_if.sv
// m_mem_access_if: split-transaction data bus (req/addr_ok/data_ok) between the M-stage access unit and memory
// master: req, wr, wstrb, addr, wdata out; addr_ok, data_ok, rdata in.  slave: the mirror image.
interface m_mem_access_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              wr;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;
  modport master(output req, wr, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave(input req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/m_mem_access.sv
// m_mem_access: M-stage memory-access unit; issues loads/stores on the data bus, extends load data, flags address errors
// clk, reset (async, active-high); respon kills the instruction in M.
// M inputs: M_valid, W_allowin, MemWriteM, MemOrALUM, MemOutSelM, MemInSelM, ALUoutM, rd2M, EXLM, ExcCodeM.
// data: master side of the data bus.  Outputs: M_allowin, M_to_W_valid, MemDataM, EXLout, ExcCodeOut.
module m_mem_access #(
  parameter int         ADDR_W   = 32,
  parameter logic [4:0] EXC_ADEL = 5'd4,
  parameter logic [4:0] EXC_ADES = 5'd5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 respon,
  input  logic                 M_valid,
  input  logic                 W_allowin,
  input  logic                 MemWriteM,
  input  logic                 MemOrALUM,
  input  logic [2:0]           MemOutSelM,
  input  logic [1:0]           MemInSelM,
  input  logic [31:0]          ALUoutM,
  input  logic [31:0]          rd2M,
  input  logic                 EXLM,
  input  logic [4:0]           ExcCodeM,
  m_mem_access_if.master       data,
  output logic                 M_allowin,
  output logic                 M_to_W_valid,
  output logic [31:0]          MemDataM,
  output logic                 EXLout,
  output logic [4:0]           ExcCodeOut
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;
  state_t      state;
  logic        memop, ld_mis, st_mis, misalign, exc_m, ready_go;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;
  always_comb begin
    memop        = MemWriteM | MemOrALUM;
    ld_mis       = (MemOutSelM == 3'd0) ? |ALUoutM[1:0] :
                   (MemOutSelM == 3'd3 || MemOutSelM == 3'd4) ? ALUoutM[0] : 1'b0;
    st_mis       = (MemInSelM == 2'd0) ? |ALUoutM[1:0] : (MemInSelM == 2'd1) ? ALUoutM[0] : 1'b0;
    misalign     = MemWriteM ? st_mis : ld_mis;
    exc_m        = EXLM | (memop & misalign);
    EXLout       = exc_m;
    ExcCodeOut   = EXLM ? ExcCodeM : (memop & misalign) ? (MemWriteM ? EXC_ADES : EXC_ADEL) : ExcCodeM;
    ready_go     = ~memop | exc_m | (state == DONE);
    M_to_W_valid = M_valid & ready_go & ~respon;
    M_allowin    = ~M_valid | (ready_go & W_allowin);
    // reset also masks the request so nothing leaks onto the bus while the FSM is being cleared
    data.req     = (state == IDLE) & M_valid & memop & ~exc_m & ~respon & ~reset;
    data.wr      = MemWriteM;
    data.addr    = {ALUoutM[ADDR_W-1:2], 2'b00};
    data.wstrb   = ~MemWriteM ? 4'b0000 : (MemInSelM == 2'd0) ? 4'b1111 :
                   (MemInSelM == 2'd1) ? 4'b0011 << ALUoutM[1:0] : 4'b0001 << ALUoutM[1:0];
    data.wdata   = (MemInSelM == 2'd0) ? rd2M : (MemInSelM == 2'd1) ? {2{rd2M[15:0]}} : {4{rd2M[7:0]}};
    byte_sel     = data.rdata[{ALUoutM[1:0], 3'b000} +: 8];
    half_sel     = ALUoutM[1] ? data.rdata[31:16] : data.rdata[15:0];
    ext          = (MemOutSelM == 3'd1) ? {24'b0, byte_sel} :
                   (MemOutSelM == 3'd2) ? {{24{byte_sel[7]}}, byte_sel} :
                   (MemOutSelM == 3'd3) ? {16'b0, half_sel} :
                   (MemOutSelM == 3'd4) ? {{16{half_sel[15]}}, half_sel} : data.rdata;
  end
  // a response that arrives with respon, or after it (DRAIN), belongs to a killed instruction and is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      MemDataM <= '0;
    end else begin
      case (state)
        IDLE:    if (data.req && data.addr_ok) state <= WAIT;
        WAIT:    if (data.data_ok) begin
                   state <= respon ? IDLE : DONE;
                   if (!respon) MemDataM <= ext;
                 end else if (respon) state <= DRAIN;
        DONE:    if (W_allowin || respon) state <= IDLE;
        DRAIN:   if (data.data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_mem_access.sv
// tb_m_mem_access: self-checking bench for m_mem_access with a load-result scoreboard
module tb_m_mem_access;
  logic        clk = 1'b0;
  logic        reset, respon, M_valid, W_allowin, MemWriteM, MemOrALUM, EXLM;
  logic [2:0]  MemOutSelM;
  logic [1:0]  MemInSelM;
  logic [31:0] ALUoutM, rd2M;
  logic [4:0]  ExcCodeM;
  logic        M_allowin, M_to_W_valid, EXLout;
  logic [31:0] MemDataM;
  logic [4:0]  ExcCodeOut;
  int          vecs = 0;
  int          errs = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  m_mem_access_if #(.ADDR_W(32)) bus();

  m_mem_access dut (
    .clk(clk), .reset(reset), .respon(respon), .M_valid(M_valid), .W_allowin(W_allowin),
    .MemWriteM(MemWriteM), .MemOrALUM(MemOrALUM), .MemOutSelM(MemOutSelM), .MemInSelM(MemInSelM),
    .ALUoutM(ALUoutM), .rd2M(rd2M), .EXLM(EXLM), .ExcCodeM(ExcCodeM), .data(bus.master),
    .M_allowin(M_allowin), .M_to_W_valid(M_to_W_valid), .MemDataM(MemDataM),
    .EXLout(EXLout), .ExcCodeOut(ExcCodeOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    respon = 0; M_valid = 0; W_allowin = 1; MemWriteM = 0; MemOrALUM = 0; EXLM = 0;
    MemOutSelM = 0; MemInSelM = 0; ALUoutM = 0; rd2M = 0; ExcCodeM = 0;
    bus.addr_ok = 0; bus.data_ok = 0; bus.rdata = 0;
  endtask

  task automatic set_load(input logic [2:0] sel, input logic [31:0] a);
    M_valid = 1; MemOrALUM = 1; MemWriteM = 0; MemOutSelM = sel; ALUoutM = a; EXLM = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (MemDataM !== 32'h0 || bus.req !== 1'b0 || M_to_W_valid !== 1'b0 || M_allowin !== 1'b1) begin
      errs++;
      $display("FAIL reset_state memdata=%h req=%b m2w=%b allowin=%b want 0 0 0 1", MemDataM, bus.req, M_to_W_valid, M_allowin);
    end
    set_load(3'd0, 32'h100);
    #1;
    vecs++;
    if (bus.req !== 1'b0) begin
      errs++;
      $display("FAIL reset_req_masked req=%b want 0", bus.req);
    end
    M_valid = 0;
    #1 reset = 0;
  endtask

  task automatic test_loads();
    logic [2:0]  sel [7] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd4, 3'd4, 3'd2};
    logic [31:0] ad  [7] = '{32'h100, 32'h103, 32'h102, 32'h101, 32'h100, 32'h102, 32'h100};
    logic [31:0] rd  [7] = '{32'h89ABCDEF, 32'h80000000, 32'h80000000, 32'h0000A500,
                             32'h00007FFF, 32'hFFFE0000, 32'h1234567F};
    logic [31:0] ex  [7] = '{32'h89ABCDEF, 32'hFFFFFF80, 32'h00008000, 32'h000000A5,
                             32'h00007FFF, 32'hFFFFFFFE, 32'h0000007F};
    for (int i = 0; i < 7; i++) begin
      step();
      set_load(sel[i], ad[i]);
      bus.addr_ok = 1;
      exp_q.push_back(ex[i]);
      @(negedge clk);
      vecs++;
      if (bus.req !== 1'b1 || bus.addr !== (ad[i] & ~32'h3) || bus.wr !== 1'b0 || EXLout !== 1'b0) begin
        errs++;
        $display("FAIL load_req[%0d] req=%b addr=%h wr=%b exl=%b want 1 %h 0 0", i, bus.req, bus.addr, bus.wr, EXLout, ad[i] & ~32'h3);
      end
      step();
      bus.addr_ok = 0; bus.data_ok = 1; bus.rdata = rd[i];
      @(negedge clk);
      vecs++;
      if (M_to_W_valid !== 1'b0 || M_allowin !== 1'b0 || bus.req !== 1'b0) begin
        errs++;
        $display("FAIL load_wait[%0d] m2w=%b allowin=%b req=%b want 0 0 0", i, M_to_W_valid, M_allowin, bus.req);
      end
      step();
      bus.data_ok = 0; bus.rdata = 32'hDEAD_0000;
      @(negedge clk);
      vecs++;
      if (M_to_W_valid !== 1'b1 || M_allowin !== 1'b1) begin
        errs++;
        $display("FAIL load_done[%0d] m2w=%b allowin=%b want 1 1", i, M_to_W_valid, M_allowin);
      end
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL load_data[%0d] scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if (MemDataM !== e) begin
          errs++;
          $display("FAIL load_data[%0d] got %h want %h", i, MemDataM, e);
        end
      end
      step();
      M_valid = 0;
    end
    repeat (3) step();
    @(negedge clk);
    vecs++;
    if (MemDataM !== 32'h0000007F) begin
      errs++;
      $display("FAIL memdata_hold got %h want 0000007f", MemDataM);
    end
  endtask

  task automatic test_stores();
    logic [1:0]  sel [4] = '{2'd2, 2'd1, 2'd0, 2'd2};
    logic [31:0] ad  [4] = '{32'h201, 32'h202, 32'h204, 32'h203};
    logic [31:0] d   [4] = '{32'h000000AB, 32'h00001234, 32'hDEADBEEF, 32'h55AA55C3};
    logic [3:0]  sb  [4] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000};
    logic [31:0] wd  [4] = '{32'hABABABAB, 32'h12341234, 32'hDEADBEEF, 32'hC3C3C3C3};
    logic [31:0] wa  [4] = '{32'h200, 32'h200, 32'h204, 32'h200};
    for (int i = 0; i < 4; i++) begin
      step();
      M_valid = 1; MemWriteM = 1; MemOrALUM = 0; MemInSelM = sel[i]; ALUoutM = ad[i]; rd2M = d[i];
      bus.addr_ok = 1;
      @(negedge clk);
      vecs++;
      if (bus.req !== 1'b1 || bus.wr !== 1'b1 || bus.wstrb !== sb[i] || bus.wdata !== wd[i] || bus.addr !== wa[i]) begin
        errs++;
        $display("FAIL store_req[%0d] req=%b wr=%b strb=%b wdata=%h addr=%h want 1 1 %b %h %h",
                 i, bus.req, bus.wr, bus.wstrb, bus.wdata, bus.addr, sb[i], wd[i], wa[i]);
      end
      step();
      bus.addr_ok = 0; bus.data_ok = 1;
      step();
      bus.data_ok = 0;
      @(negedge clk);
      vecs++;
      if (M_to_W_valid !== 1'b1 || EXLout !== 1'b0) begin
        errs++;
        $display("FAIL store_done[%0d] m2w=%b exl=%b want 1 0", i, M_to_W_valid, EXLout);
      end
      step();
      M_valid = 0; MemWriteM = 0;
    end
  endtask

  task automatic test_misalign();
    logic        wr  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  os  [5] = '{3'd0, 3'd0, 3'd4, 3'd0, 3'd0};
    logic [1:0]  is  [5] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    logic [31:0] ad  [5] = '{32'h102, 32'h101, 32'h103, 32'h100, 32'h202};
    logic        ux  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0]  uc  [5] = '{5'd0, 5'd0, 5'd0, 5'd10, 5'd0};
    logic [4:0]  ec  [5] = '{5'd4, 5'd5, 5'd4, 5'd10, 5'd5};
    for (int i = 0; i < 5; i++) begin
      step();
      M_valid = 1; MemWriteM = wr[i]; MemOrALUM = ~wr[i]; MemOutSelM = os[i]; MemInSelM = is[i];
      ALUoutM = ad[i]; EXLM = ux[i]; ExcCodeM = uc[i]; W_allowin = 1;
      @(negedge clk);
      vecs++;
      if (bus.req !== 1'b0 || EXLout !== 1'b1 || ExcCodeOut !== ec[i] || M_to_W_valid !== 1'b1 || M_allowin !== 1'b1) begin
        errs++;
        $display("FAIL misalign[%0d] req=%b exl=%b code=%0d m2w=%b allowin=%b want 0 1 %0d 1 1",
                 i, bus.req, EXLout, ExcCodeOut, M_to_W_valid, M_allowin, ec[i]);
      end
    end
    step();
    idle_inputs();
  endtask

  task automatic test_stall();
    step();
    set_load(3'd0, 32'h300);
    W_allowin = 0;
    exp_q.push_back(32'h11223344);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h300 || M_allowin !== 1'b0) begin
        errs++;
        $display("FAIL stall_hold[%0d] req=%b addr=%h allowin=%b want 1 300 0", i, bus.req, bus.addr, M_allowin);
      end
      step();
    end
    bus.addr_ok = 1;
    @(negedge clk);
    vecs++;
    if (bus.req !== 1'b1 || M_allowin !== 1'b0) begin
      errs++;
      $display("FAIL stall_accept req=%b allowin=%b want 1 0", bus.req, M_allowin);
    end
    step();
    bus.addr_ok = 0; bus.data_ok = 1; bus.rdata = 32'h11223344;
    step();
    bus.data_ok = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vecs++;
      if (M_to_W_valid !== 1'b1 || M_allowin !== 1'b0 || bus.req !== 1'b0) begin
        errs++;
        $display("FAIL stall_done[%0d] m2w=%b allowin=%b req=%b want 1 0 0", i, M_to_W_valid, M_allowin, bus.req);
      end
      step();
    end
    W_allowin = 1;
    @(negedge clk);
    vecs++;
    if (M_allowin !== 1'b1 || exp_q.size() == 0) begin
      errs++;
      $display("FAIL stall_release allowin=%b queued=%0d want 1 1", M_allowin, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      vecs++;
      if (MemDataM !== e) begin
        errs++;
        $display("FAIL stall_data got %h want %h", MemDataM, e);
      end
    end
    step();
    M_valid = 0;
  endtask

  task automatic test_flush();
    step();
    set_load(3'd0, 32'h400);
    bus.addr_ok = 1;
    step();
    bus.addr_ok = 0; respon = 1;
    @(negedge clk);
    vecs++;
    if (M_to_W_valid !== 1'b0 || bus.req !== 1'b0) begin
      errs++;
      $display("FAIL flush_kill m2w=%b req=%b want 0 0", M_to_W_valid, bus.req);
    end
    step();
    respon = 0;
    set_load(3'd0, 32'h500);
    @(negedge clk);
    vecs++;
    if (bus.req !== 1'b0 || M_to_W_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_drain req=%b m2w=%b want 0 0", bus.req, M_to_W_valid);
    end
    step();
    bus.data_ok = 1; bus.rdata = 32'hBAD0BAD0;
    @(negedge clk);
    vecs++;
    if (bus.req !== 1'b0 || M_to_W_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_stale_ok req=%b m2w=%b want 0 0", bus.req, M_to_W_valid);
    end
    step();
    bus.data_ok = 0; bus.addr_ok = 1;
    exp_q.push_back(32'h0F0F0F0F);
    @(negedge clk);
    vecs++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h500 || MemDataM !== 32'h11223344) begin
      errs++;
      $display("FAIL flush_reissue req=%b addr=%h memdata=%h want 1 500 11223344", bus.req, bus.addr, MemDataM);
    end
    step();
    bus.addr_ok = 0; bus.data_ok = 1; bus.rdata = 32'h0F0F0F0F;
    step();
    bus.data_ok = 0;
    @(negedge clk);
    vecs++;
    if (M_to_W_valid !== 1'b1 || exp_q.size() == 0) begin
      errs++;
      $display("FAIL flush_next m2w=%b queued=%0d want 1 1", M_to_W_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      vecs++;
      if (MemDataM !== e) begin
        errs++;
        $display("FAIL flush_next_data got %h want %h", MemDataM, e);
      end
    end
    step();
    M_valid = 0;
  endtask

  task automatic test_reset_wait();
    step();
    set_load(3'd0, 32'h600);
    bus.addr_ok = 1;
    step();
    bus.addr_ok = 0;
    @(negedge clk);
    #2 reset = 1;
    #1;
    vecs++;
    if (bus.req !== 1'b0 || M_to_W_valid !== 1'b0 || MemDataM !== 32'h0) begin
      errs++;
      $display("FAIL reset_wait req=%b m2w=%b memdata=%h want 0 0 0", bus.req, M_to_W_valid, MemDataM);
    end
    #1 reset = 0;
    #1;
    vecs++;
    if (bus.req !== 1'b1) begin
      errs++;
      $display("FAIL reset_idle req=%b want 1", bus.req);
    end
    M_valid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_stall();
    test_flush();
    test_reset_wait();
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_leftover %0d entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/m_mem_access.md
Name: m_mem_access

Overview:
- Memory-access unit of the M stage. It sits directly downstream of the E->M pipeline register and consumes its M-side outputs.
- Issues the load/store for the instruction held in M onto a split-transaction data bus (req/addr_ok/data_ok).
- Generates byte strobes, extends load data and detects address-alignment exceptions.
- Produces the M-stage handshake signals (M_allowin, M_to_W_valid) that gate the E->M and M->W registers.

Parameters:
- ADDR_W, 32, data-bus address width.
- EXC_ADEL, 5'd4, ExcCode for a load or fetch address error.
- EXC_ADES, 5'd5, ExcCode for a store address error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- respon  in  1  exception/flush response; kills the instruction in M this cycle.
- M_valid  in  1  M register holds a valid instruction.
- W_allowin  in  1  W stage can accept.
- MemWriteM  in  1  store.
- MemOrALUM  in  1  load (1) / ALU result (0).
- MemOutSelM  in  3  load type: 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh.
- MemInSelM  in  2  store type: 0 sw, 1 sh, 2 sb.
- ALUoutM  in  32  effective address.
- rd2M  in  32  store data.
- EXLM  in  1  exception already raised upstream.
- ExcCodeM  in  5  upstream ExcCode.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_wstrb  out  4  byte enables.
- data_addr  out  ADDR_W  word-aligned address (addr[1:0] = 0).
- data_wdata  out  32  store data, lane-replicated.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response; read data valid, or write done.
- data_rdata  in  32  read data.
- M_allowin  out  1  M register may load.
- M_to_W_valid  out  1  valid instruction ready for W.
- MemDataM  out  32  extended load result.
- EXLout  out  1  exception flag forwarded to W.
- ExcCodeOut  out  5  ExcCode forwarded to W.

Behaviour:
- Reset (async) puts state in IDLE, MemDataM 0, data_req 0.
- memop = MemWriteM | MemOrALUM.
- Alignment rules:
  - misalign: lw/sw when addr[1:0] != 0; lh/lhu/sh when addr[0] != 0.
  - excM = EXLM | (memop & misalign).
  - EXLout = excM.
  - ExcCodeOut = ExcCodeM if EXLM, else ADEL (load) or ADES (store) when misaligned.
- States: IDLE, WAIT, DONE, DRAIN.
- IDLE:
  - data_req = M_valid & memop & ~excM & ~respon.
  - addr_ok & req -> WAIT.
  - data_req is held until addr_ok; address, strobe and data must stay stable meanwhile (they derive from the M register, which does not change while M_allowin = 0).
- WAIT:
  - data_ok -> capture extended data into MemDataM, go to DONE.
  - data_ok in the same cycle as respon -> IDLE, result discarded.
  - respon without data_ok -> DRAIN.
- DONE:
  - W_allowin | respon -> IDLE.
- DRAIN:
  - data_req = 0; data_ok -> IDLE.
  - A new instruction in M cannot issue until the FSM is back in IDLE.
- ready_go = ~memop | excM | (state == DONE).
- M_to_W_valid = M_valid & ready_go & ~respon.
- M_allowin = ~M_valid | (ready_go & W_allowin).
- Minimum load/store latency: request cycle (addr_ok same cycle), data_ok next cycle, ready_go in the following cycle.
- Store strobes:
  - sw: 1111.
  - sh: 0011 << addr[1:0].
  - sb: 0001 << addr[1:0].
  - wdata: sw passthrough; sh {2{rd2[15:0]}}; sb {4{rd2[7:0]}}.
- Load extension: select byte addr[1:0] or half addr[1]; lb/lh sign-extend, lbu/lhu zero-extend.
- MemDataM holds its value until the next capture.
- Exception instructions never raise data_req and pass through with ready_go = 1.

Test Plan:
- lw at 0x100, addr_ok same cycle, data_ok +1 with rdata 0x89ABCDEF -> MemDataM = 0x89ABCDEF, M_to_W_valid the cycle after data_ok.
- lb at 0x103, rdata 0x80000000 -> MemDataM = 0xFFFFFF80. lhu at 0x102, rdata 0x80000000 -> MemDataM = 0x00008000.
- sb at 0x201 with rd2 0x000000AB -> data_wstrb 0010, data_wdata 0xABABABAB, data_addr 0x200, data_wr 1.
- lw at 0x102 -> no data_req, EXLout 1, ExcCodeOut 4, M_to_W_valid same cycle. sh at 0x101 -> ExcCodeOut 5.
- addr_ok delayed 3 cycles, then W_allowin = 0 for 2 cycles after data_ok -> req held stable, M_allowin 0 throughout, state stays DONE until W_allowin.
- respon in WAIT, then data_ok 2 cycles later while a new lw sits in M -> the old result is not forwarded, and the new lw's data_req rises only after data_ok returns the FSM to IDLE.
- Assert reset during WAIT -> state IDLE immediately, data_req 0.
